// File: rtl/ext_irq_ctrl_if.sv
// ext_irq_ctrl_if: ExtIRQ/ExtIAck handshake between the interrupt controller and the processor controller
interface ext_irq_ctrl_if #(
    parameter int N_SRC = 4
);
    localparam int IDW = $clog2(N_SRC);
    logic           ExtIRQ;
    logic           ExtIAck;
    logic [IDW-1:0] irq_id;
    modport master (output ExtIRQ, output irq_id, input ExtIAck);
    modport slave  (input ExtIRQ, input irq_id, output ExtIAck);
endinterface

// File: rtl/ext_irq_ctrl.sv
// ext_irq_ctrl: edge-triggered external interrupt controller, fixed lowest-index priority
// Optional macro IRQ_TIMEOUT_EN: drop an unacknowledged request after TIMEOUT cycles and flag irq_lost.
module ext_irq_ctrl #(
    parameter int N_SRC       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 255
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_SRC-1:0]   irq_src,
    input  logic [N_SRC-1:0]   irq_mask,
    ext_irq_ctrl_if.master     bus,
    output logic [N_SRC-1:0]   irq_pending,
    output logic               irq_lost
);
    localparam int IDW = $clog2(N_SRC);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] GAP  = 2'd2;

    logic [SYNC_STAGES-1:0][N_SRC-1:0] sync_q;
    logic [N_SRC-1:0] dly_q, rise, cand, clr;
    logic [1:0]       state;
    logic [IDW-1:0]   id_q, pick;
    logic             ack, expire;

    assign rise   = sync_q[SYNC_STAGES-1] & ~dly_q;
    assign cand   = irq_pending & irq_mask;
    assign ack    = (state == REQ) && bus.ExtIAck;
    assign clr    = (ack || expire) ? (N_SRC'(1) << id_q) : '0;
    assign bus.ExtIRQ = (state == REQ);
    assign bus.irq_id = id_q;

    // lowest-index candidate wins
    always_comb begin
        pick = '0;
        for (int i = N_SRC - 1; i >= 0; i--)
            if (cand[i]) pick = IDW'(i);
    end

    // synchronize source lines and keep a delayed copy for edge detection
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
            dly_q  <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], irq_src};
            dly_q  <= sync_q[SYNC_STAGES-1];
        end
    end

    // pending bits: a new edge wins over a same-cycle retire
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) irq_pending <= '0;
        else        irq_pending <= (irq_pending & ~clr) | rise;
    end

    // request FSM; leaving GAP may latch the next candidate so back-to-back requests are one cycle apart
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            id_q  <= '0;
        end else if (state == REQ) begin
            if (ack || expire) state <= GAP;
        end else if (cand != '0) begin
            state <= REQ;
            id_q  <= pick;
        end else begin
            state <= IDLE;
        end
    end

`ifdef IRQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] cnt;

    assign expire = (state == REQ) && !bus.ExtIAck && (cnt == TW'(TIMEOUT - 1));

    // count cycles spent in REQ; restarts from zero on every entry
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)              cnt <= '0;
        else if (state == REQ)   cnt <= cnt + 1'b1;
        else                     cnt <= '0;
    end

    // sticky record that a request was dropped unacknowledged
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)      irq_lost <= 1'b0;
        else if (expire) irq_lost <= 1'b1;
    end
`else
    assign expire   = 1'b0;
    assign irq_lost = 1'b0;
`endif
endmodule

// File: doc/ext_irq_ctrl.md
Name: ext_irq_ctrl

Overview:
External interrupt controller on the requester side of the CPU exception interface. It collects interrupt edges from N_SRC peripheral lines and holds them as pending bits. It raises ExtIRQ toward the processor controller and holds it until the controller returns ExtIAck. On ExtIAck it retires the serviced source and presents the next one.

Parameters:
N_SRC, 4, number of interrupt source lines (2..16)
SYNC_STAGES, 2, flip-flop synchronizer depth per source line (>=2)
TIMEOUT, 255, cycles ExtIRQ may stay unacknowledged (used only with IRQ_TIMEOUT_EN)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
irq_src  input  N_SRC  asynchronous peripheral interrupt lines, rising-edge significant
irq_mask  input  N_SRC  1 = source enabled; synchronous to clk
ExtIAck  input  1  acknowledge from processor controller; valid only while ExtIRQ=1
ExtIRQ  output  1  interrupt request to processor controller
irq_id  output  $clog2(N_SRC)  index of the source being requested; stable while ExtIRQ=1
irq_pending  output  N_SRC  current pending bits, for software readout
irq_lost  output  1  sticky timeout flag (constant 0 without IRQ_TIMEOUT_EN)

Behaviour:
- Reset (reset=0, async): all synchronizer flops 0, pending=0, state=IDLE, ExtIRQ=0, irq_id=0, irq_lost=0, timeout counter=0. Reset asserted mid-request drops ExtIRQ immediately. No pending state survives reset.
- Each irq_src bit passes through SYNC_STAGES flops, then a 1-cycle-delayed copy. An edge is sync=1 and delayed=0.
- An edge sets pending[i] regardless of mask. Masked sources stay pending but are never requested.
- Candidate set = pending & irq_mask. Fixed priority: lowest index wins.
- FSM:
  - IDLE: if candidate set is non-zero, latch irq_id = highest-priority index and go to REQ.
  - REQ: ExtIRQ=1, irq_id held. On ExtIAck=1, clear pending[irq_id] and go to GAP.
  - GAP: ExtIRQ=0 for exactly one cycle, then IDLE. This prevents the controller's combinational ExtIAck from double-acknowledging.
- Latency: edge visible on irq_src at cycle 0 -> ExtIRQ=1 at cycle SYNC_STAGES+2.
- Back-to-back: with another candidate pending, the next ExtIRQ rises 2 cycles after the ack cycle (GAP, then IDLE latch).
- A higher-priority edge arriving during REQ does not preempt. irq_id stays fixed until ack.
- If a mask bit for irq_id is cleared during REQ, the request is still held until ack (no withdrawal).
- Same-cycle edge on source i and clear of pending[i]: set wins, so pending[i] stays 1.
- Repeat edges on an already-pending source coalesce. There is no counting.
- ExtIAck while not in REQ is ignored.

Optional Feature:
IRQ_TIMEOUT_EN
- Defined: in REQ a counter increments each cycle. When it reaches TIMEOUT with no ExtIAck:
  - pending[irq_id] is cleared;
  - irq_lost is set (sticky until reset);
  - FSM goes to GAP.
  - The counter clears on entry to REQ.
  - ExtIAck in the same cycle as the counter reaching TIMEOUT counts as a normal ack; irq_lost is not set.
- Undefined: no counter; REQ waits indefinitely; irq_lost tied to 0.

Test Plan:
- Reset with irq_src=4'b0000, then rise irq_src[2] at cycle 0 with mask=4'hF -> ExtIRQ=1 and irq_id=2 at cycle 4; pending=4'b0100.
- Hold ExtIRQ for 3 cycles, then pulse ExtIAck for 1 cycle -> pending=0 the next cycle, ExtIRQ=0 for 1 cycle, and ExtIRQ stays 0 afterwards.
- Rise irq_src[3] and irq_src[1] in the same cycle -> id=1 first; after ack, ExtIRQ re-rises 2 cycles later with id=3.
- mask=4'b1110 and edge on src[0] -> pending[0]=1 and ExtIRQ stays 0. Then set mask=4'hF -> ExtIRQ=1, id=0.
- Drop reset to 0 while ExtIRQ=1 -> ExtIRQ=0 asynchronously (same cycle). After reset release, pending=0 and ExtIRQ=0.
- With IRQ_TIMEOUT_EN and TIMEOUT=8, request with no ack -> after 8 cycles in REQ: ExtIRQ=0, pending bit cleared, irq_lost=1 and held.
